// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: state encodings, widths and the
// default boot PC.
package fetch_ctrl_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Redirect targets are word aligned; the low byte-offset bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding {pc, inst} pairs; the head entry is presented
// directly so decode sees a registered value one cycle after the push.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_pop;
  logic w_push;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_pop  = pop && !empty && !flush;
  assign w_push = push && !flush && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, addresses the combinational instruction
// memory and hands {pc, inst} pairs to decode through a small buffer.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  input  logic              if_ready
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;

  logic        w_full;
  logic        w_empty;
  logic [63:0] w_head;
  logic        w_pop;
  logic        w_fetch;

  assign w_pop   = !w_empty && if_ready;
  // A redirect suppresses the fetch so the stale pc never enters the buffer.
  assign w_fetch = (r_state == ST_RUN) && !redirect_valid && (!w_full || w_pop);

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      if (r_state == ST_RUN && halt) begin
        w_state_next = ST_HALTED;
      end
    end else begin
      case (r_state)
        ST_IDLE:   if (start && !halt) w_state_next = ST_RUN;
        ST_RUN:    if (halt)           w_state_next = ST_HALTED;
        ST_HALTED: if (start && !halt) w_state_next = ST_RUN;
        default:                       w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_pc <= align_pc(redirect_pc);
      end else if (w_fetch) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fetch),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   ({r_pc, imem_data}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign imem_addr = {2'b00, r_pc[31:2]};
  assign if_valid  = !w_empty;
  assign if_pc     = w_empty ? 32'h0 : w_head[63:32];
  assign if_inst   = w_empty ? {INST_W{1'b0}} : w_head[31:0];

endmodule
